seq_div_16by8: RTL and testbench
================================

# seq_div_16by8

Sequential signed divider: a 16-bit two's-complement dividend divided by an 8-bit two's-complement divisor gives an 8-bit quotient and an 8-bit remainder. It uses a restoring, one-bit-per-cycle algorithm. It is the inverse companion of the 8x8 sequential multiplier in the arithmetic datapath and uses the same clock/reset domain with a start/ready handshake. Division truncates toward zero (C semantics), and the remainder takes the dividend's sign.

## Interface
- No parameters; widths fixed at 16/8.
- clk  input  1  rising-edge clock.
- reset  input  1  reset, asynchronous, active-high; clock clk.
- start  input  1  request; sampled only when idle (busy=0).
- dividend  input  16  signed dividend; captured on accepted start.
- divisor  input  8  signed divisor; captured on accepted start.
- quotient  output  8  signed quotient; held until next completion.
- remainder  output  8  signed remainder; held until next completion.
- busy  output  1  high while a division is in progress.
- rdy  output  1  one-cycle pulse marking the cycle in which results become valid.
- div_zero  output  1  last completed operation had divisor==0; held with the results.
- ovf  output  1  last true quotient was outside [-128,127]; held with the results.

## Operation
- States: IDLE, LOAD, DIV, FIX.
- IDLE→LOAD on a rising edge with start=1.
  - Dividend and divisor are latched, along with the sign flags sq = dividend[15]^divisor[7] and sr = dividend[15].
- LOAD:
  - Forms unsigned magnitudes: 16-bit |dividend| (-32768 → 0x8000) and 8-bit |divisor| (-128 → 0x80).
  - Clears the 9-bit partial remainder and sets the iteration counter to 15.
  - If the divisor is 0, goes to FIX with div_zero pending; otherwise goes to DIV.
- DIV, one iteration per cycle, 16 cycles, MSB first:
  - Shift the next dividend bit into the partial remainder.
  - Trial-subtract |divisor|.
  - If the result is non-negative, keep it and set quotient bit = 1; otherwise restore and set quotient bit = 0.
  - After the counter reaches 0, go to FIX.
- FIX → IDLE; registers outputs and pulses rdy. The signed quotient is the 16-bit magnitude quotient, negated if sq.
  - Remainder: magnitude remainder negated if sr. It always fits in 8 bits, since |rem| ≤ 127.
  - If the signed quotient is outside [-128,127]: ovf=1, and quotient saturates to 0x7F (positive) or 0x80 (negative).
  - Zero divisor: div_zero=1, ovf=0, quotient=0x00, remainder=dividend[7:0].
  - All other cases: div_zero=0 and ovf is computed.
- Start while busy is ignored and has no effect on the running operation.
- Start in the same cycle that rdy is high is accepted, because the state is already IDLE.
- Reset, at any time including mid-operation:
  - State returns to IDLE.
  - quotient=0, remainder=0, busy=0, rdy=0, div_zero=0, ovf=0; internal registers cleared.
  - No stale rdy after reset release.

## Timing
- E0 is the rising edge that samples start=1 in IDLE.
- busy=1 from just after E0 until the completion edge.
- Normal latency: LOAD at E1, DIV iterations at E2..E17, FIX outputs at E18.
  - After E18: quotient, remainder and flags valid, rdy=1, busy=0.
  - After E19: rdy=0 and results held.
- Zero-divisor latency: results and rdy=1 after E2.
- Back-to-back throughput: one division per 19 cycles if start is asserted in the rdy cycle.
- Outputs change only on completion edges or reset; no combinational path from inputs to outputs.

## Test plan
- 100 / 7: dividend=0x0064, divisor=0x07, start for 1 cycle → after 18 edges quotient=0x0E, remainder=0x02, ovf=0, div_zero=0, rdy pulse exactly 1 cycle.
- -100 / 7 and 100 / -7:
  - dividend=0xFF9C, divisor=0x07 → quotient=0xF2 (-14), remainder=0xFE (-2).
  - 100 / -7 → quotient=0xF2, remainder=0x02.
- Overflow cases:
  - 1000 / 3 (0x03E8/0x03) → ovf=1, quotient=0x7F, remainder=0x01.
  - -32768 / -128 (0x8000/0x80) → ovf=1, quotient=0x7F, remainder=0x00.
  - -32768 / 1 → ovf=1, quotient=0x80, remainder=0x00.
- Divide by zero: 0x1234 / 0x00 → rdy after 2 edges, div_zero=1, quotient=0x00, remainder=0x34, ovf=0.
- Handshake:
  - Re-assert start mid-operation with different operands → first result unchanged, no extra rdy.
  - Assert start in the rdy cycle → second result rdy 19 cycles later.
- Reset at iteration 8 of 50 / 5 → all outputs 0 immediately. A following 50 / 5 completes normally: quotient=0x0A, remainder=0x00.

Source files
------------

// File: rtl/seq_div_16by8.sv
// seq_div_16by8 - sequential signed divider, 16-bit dividend / 8-bit divisor.
// Restoring algorithm, one quotient bit per cycle on magnitudes, with the
// signs applied and the 8-bit result range checked in a final fix-up cycle.
// Quotient truncates toward zero; the remainder takes the dividend's sign.
//
// Ports:
//   clk        rising-edge clock
//   reset      asynchronous, active-high
//   start      request, sampled only while idle
//   dividend   16-bit signed dividend, captured on an accepted start
//   divisor    8-bit signed divisor, captured on an accepted start
//   quotient   8-bit signed quotient (saturated on overflow), held
//   remainder  8-bit signed remainder, held
//   busy       division in progress
//   rdy        one-cycle pulse when results update
//   div_zero   last operation had divisor == 0
//   ovf        last true quotient was outside [-128,127]
module seq_div_16by8 (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [15:0] dividend,
  input  logic [7:0]  divisor,
  output logic [7:0]  quotient,
  output logic [7:0]  remainder,
  output logic        busy,
  output logic        rdy,
  output logic        div_zero,
  output logic        ovf
);

  typedef enum logic [1:0] {IDLE, LOAD, DIV, FIX} state_t;
  state_t state, state_nx;

  logic [15:0] dvd_r;     // captured operands
  logic [7:0]  dvs_r;
  logic        sq, sr;    // quotient / remainder sign
  logic [7:0]  dvs_mag;
  logic [15:0] dq;        // dividend magnitude shifting out, quotient bits shifting in
  logic [8:0]  prem;      // partial remainder
  logic [3:0]  cnt;
  logic        dz_pend;

  // Iteration datapath
  logic [9:0]  shifted;
  logic [8:0]  trial;
  logic        ge;

  assign shifted = {prem, dq[15]};
  assign trial   = shifted[8:0] - {1'b0, dvs_mag};
  assign ge      = (shifted >= {2'b00, dvs_mag});

  // Fix-up: sign application and range check
  logic [7:0] q_fix, r_fix;
  logic       ovf_fix;

  always_comb begin
    ovf_fix = sq ? (dq > 16'd128) : (dq > 16'd127);
    if (ovf_fix)
      q_fix = sq ? 8'h80 : 8'h7F;
    else
      q_fix = sq ? (8'd0 - dq[7:0]) : dq[7:0];
    // remainder magnitude is always below |divisor| <= 128, so it fits
    r_fix = sr ? (8'd0 - prem[7:0]) : prem[7:0];
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE: if (start) state_nx = LOAD;
      LOAD: state_nx = (dvs_r == 8'd0) ? FIX : DIV;
      DIV:  if (cnt == 4'd0) state_nx = FIX;
      FIX:  state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nx;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      dvd_r     <= '0;
      dvs_r     <= '0;
      sq        <= 1'b0;
      sr        <= 1'b0;
      dvs_mag   <= '0;
      dq        <= '0;
      prem      <= '0;
      cnt       <= '0;
      dz_pend   <= 1'b0;
      quotient  <= '0;
      remainder <= '0;
      rdy       <= 1'b0;
      div_zero  <= 1'b0;
      ovf       <= 1'b0;
    end else begin
      rdy <= 1'b0;
      case (state)
        IDLE: if (start) begin
          dvd_r <= dividend;
          dvs_r <= divisor;
          sq    <= dividend[15] ^ divisor[7];
          sr    <= dividend[15];
        end
        LOAD: begin
          // -32768 -> 0x8000 and -128 -> 0x80 fall out of the two's-complement negate
          dq      <= dvd_r[15] ? (16'd0 - dvd_r) : dvd_r;
          dvs_mag <= dvs_r[7]  ? (8'd0 - dvs_r)  : dvs_r;
          prem    <= '0;
          cnt     <= 4'd15;
          dz_pend <= (dvs_r == 8'd0);
        end
        DIV: begin
          prem <= ge ? trial : shifted[8:0];
          dq   <= {dq[14:0], ge};
          cnt  <= cnt - 4'd1;
        end
        FIX: begin
          rdy <= 1'b1;
          if (dz_pend) begin
            quotient  <= 8'h00;
            remainder <= dvd_r[7:0];
            div_zero  <= 1'b1;
            ovf       <= 1'b0;
          end else begin
            quotient  <= q_fix;
            remainder <= r_fix;
            div_zero  <= 1'b0;
            ovf       <= ovf_fix;
          end
        end
        default: ;
      endcase
    end
  end

  assign busy = (state != IDLE);

endmodule

// File: tb/tb_seq_div_16by8.sv
module tb_seq_div_16by8;
  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [15:0] dividend;
  logic [7:0]  divisor;
  logic [7:0]  quotient, remainder;
  logic        busy, rdy, div_zero, ovf;

  int n_assert = 0;
  int n_fail   = 0;
  int lat;

  seq_div_16by8 dut (
    .clk(clk), .reset(reset), .start(start),
    .dividend(dividend), .divisor(divisor),
    .quotient(quotient), .remainder(remainder),
    .busy(busy), .rdy(rdy), .div_zero(div_zero), .ovf(ovf)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Drive a request across one rising edge (E0); returns just after E0.
  task automatic start_op(input logic [15:0] a, input logic [7:0] b);
    @(negedge clk);
    dividend = a;
    divisor  = b;
    start    = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  // Counts rising edges until rdy is seen, bounded.
  task automatic wait_rdy(output int n);
    n = 0;
    do begin
      @(posedge clk); #1;
      n++;
    end while (!rdy && n < 40);
  endtask

  task automatic check_res(input string tag, input logic [7:0] q, input logic [7:0] r,
                           input logic o, input logic z);
    chk({tag, " quotient"},  {8'h0, quotient},  {8'h0, q});
    chk({tag, " remainder"}, {8'h0, remainder}, {8'h0, r});
    chk({tag, " ovf"},       {15'h0, ovf},      {15'h0, o});
    chk({tag, " div_zero"},  {15'h0, div_zero}, {15'h0, z});
    chk({tag, " busy"},      {15'h0, busy},     16'h0);
  endtask

  // Full operation: latency, results, then one-cycle rdy with results held.
  task automatic run_op(input string tag, input logic [15:0] a, input logic [7:0] b,
                        input int exp_lat, input logic [7:0] q, input logic [7:0] r,
                        input logic o, input logic z);
    start_op(a, b);
    chk({tag, " busy after start"}, {15'h0, busy}, 16'h1);
    wait_rdy(lat);
    chk({tag, " latency"}, lat[15:0], exp_lat[15:0]);
    check_res(tag, q, r, o, z);
    @(posedge clk); #1;
    chk({tag, " rdy drop"},   {15'h0, rdy},     16'h0);
    chk({tag, " q held"},     {8'h0, quotient}, {8'h0, q});
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; dividend = '0; divisor = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset quotient",  {8'h0, quotient},  16'h0);
    chk("reset remainder", {8'h0, remainder}, 16'h0);
    chk("reset busy",      {15'h0, busy},     16'h0);
    chk("reset rdy",       {15'h0, rdy},      16'h0);
    chk("reset flags",     {14'h0, ovf, div_zero}, 16'h0);
    @(negedge clk); reset = 1'b0;

    run_op("100/7",      16'h0064, 8'h07, 18, 8'h0E, 8'h02, 1'b0, 1'b0);
    run_op("-100/7",     16'hFF9C, 8'h07, 18, 8'hF2, 8'hFE, 1'b0, 1'b0);
    run_op("100/-7",     16'h0064, 8'hF9, 18, 8'hF2, 8'h02, 1'b0, 1'b0);
    run_op("-100/-7",    16'hFF9C, 8'hF9, 18, 8'h0E, 8'hFE, 1'b0, 1'b0);
    run_op("1000/3",     16'h03E8, 8'h03, 18, 8'h7F, 8'h01, 1'b1, 1'b0);
    run_op("-32768/-128",16'h8000, 8'h80, 18, 8'h7F, 8'h00, 1'b1, 1'b0);
    run_op("-32768/1",   16'h8000, 8'h01, 18, 8'h80, 8'h00, 1'b1, 1'b0);
    run_op("-1280/10",   16'hFB00, 8'h0A, 18, 8'h80, 8'h00, 1'b0, 1'b0);
    run_op("1280/10",    16'h0500, 8'h0A, 18, 8'h7F, 8'h00, 1'b1, 1'b0);
    run_op("div0",       16'h1234, 8'h00, 2,  8'h00, 8'h34, 1'b0, 1'b1);
    run_op("after div0", 16'h0032, 8'h05, 18, 8'h0A, 8'h00, 1'b0, 1'b0);

    // start re-asserted mid-operation is ignored
    start_op(16'h0064, 8'h07);
    repeat (5) @(posedge clk);
    @(negedge clk);
    dividend = 16'h1234; divisor = 8'h03; start = 1'b1;
    repeat (4) @(posedge clk);
    @(negedge clk); start = 1'b0;
    wait_rdy(lat);
    chk("midstart latency", lat[15:0], 16'd9);
    check_res("midstart", 8'h0E, 8'h02, 1'b0, 1'b0);
    repeat (3) begin
      @(posedge clk); #1;
      chk("midstart no extra rdy", {14'h0, busy, rdy}, 16'h0);
    end

    // start in the rdy cycle is accepted: next result 19 cycles later
    start_op(16'h03E8, 8'h07);
    wait_rdy(lat);
    chk("b2b first latency", lat[15:0], 16'd18);
    check_res("b2b first", 8'h7F, 8'h06, 1'b1, 1'b0);
    dividend = 16'hFF9C; divisor = 8'h07; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    chk("b2b accepted busy", {15'h0, busy}, 16'h1);
    wait_rdy(lat);
    chk("b2b second latency", lat[15:0] + 16'd1, 16'd19);
    check_res("b2b second", 8'hF2, 8'hFE, 1'b0, 1'b0);

    // reset at iteration 8 of 50/5
    start_op(16'h0032, 8'h05);
    repeat (9) @(posedge clk);
    #1 reset = 1'b1;
    #1;
    chk("midreset quotient",  {8'h0, quotient},  16'h0);
    chk("midreset remainder", {8'h0, remainder}, 16'h0);
    chk("midreset busy/rdy",  {14'h0, busy, rdy}, 16'h0);
    chk("midreset flags",     {14'h0, ovf, div_zero}, 16'h0);
    repeat (2) @(posedge clk);
    @(negedge clk); reset = 1'b0;
    repeat (20) begin
      @(posedge clk); #1;
      chk("no stale rdy", {14'h0, busy, rdy}, 16'h0);
    end
    run_op("50/5 post reset", 16'h0032, 8'h05, 18, 8'h0A, 8'h00, 1'b0, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
